// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the regfile writeback arbiter: FSM state encodings and
// the register index that is never written.
package regfile_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FORCE = 2'd2
    } arbState_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_wb_arbiter_hold_buffer.sv
// One-entry parking slot for a multdiv result that lost the write port to the pipeline.
module wb_hold_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] loadReg,
    input  logic [DATA_W-1:0] loadData,
    output logic              valid,
    output logic [ADDR_W-1:0] heldReg,
    output logic [DATA_W-1:0] heldData
);

    // Clear wins over load; the arbiter never requests both in one cycle.
    always_ff @(posedge clock) begin
        if (!resetN || clear) begin
            valid    <= 1'b0;
            heldReg  <= '0;
            heldData <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            heldReg  <= loadReg;
            heldData <= loadData;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between W-stage writeback (priority) and
// multdiv completion, parking a colliding multdiv result and forcing a drain on starvation.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_reg,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_reg,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_reg,
    output logic [DATA_W-1:0] rf_data,
    output logic              stall_pipe,
    output logic              hold_valid,
    output logic [ADDR_W-1:0] hold_reg,
    output logic              md_dropped,
    output logic              pipe_err
);

    localparam int                CNT_W    = $clog2(STARVE_LIMIT) + 1;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    arbState_t         state, nextState;
    logic [CNT_W-1:0]  holdCnt, nextHoldCnt;
    logic              stallReg, nextStall;
    logic              bufLoad, bufClear, bufValid;
    logic [ADDR_W-1:0] bufReg;
    logic [DATA_W-1:0] bufData;
    logic              candWe;
    logic [ADDR_W-1:0] candReg;
    logic [DATA_W-1:0] candData;
    logic              mdReadyInt, mdDropInt, pipeErrInt, rfWeInt;

    wb_hold_buffer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) holdBuffer (
        .clock   (clock),
        .resetN  (ctrl_reset_n),
        .load    (bufLoad),
        .clear   (bufClear),
        .loadReg (md_reg),
        .loadData(md_data),
        .valid   (bufValid),
        .heldReg (bufReg),
        .heldData(bufData)
    );

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            state    <= ST_IDLE;
            holdCnt  <= '0;
            stallReg <= 1'b0;
        end else begin
            state    <= nextState;
            holdCnt  <= nextHoldCnt;
            stallReg <= nextStall;
        end
    end

    // A multdiv result aimed at r0 is accepted and silently swallowed, never parked.
    always_comb begin
        nextState   = state;
        nextHoldCnt = holdCnt;
        nextStall   = stallReg;
        bufLoad     = 1'b0;
        bufClear    = 1'b0;
        candWe      = 1'b0;
        candReg     = '0;
        candData    = '0;
        mdReadyInt  = 1'b0;
        mdDropInt   = 1'b0;
        pipeErrInt  = 1'b0;
        case (state)
            ST_IDLE: begin
                mdReadyInt = 1'b1;
                if (pipe_we) begin
                    candWe   = 1'b1;
                    candReg  = pipe_reg;
                    candData = pipe_data;
                end else if (md_valid) begin
                    candWe   = 1'b1;
                    candReg  = md_reg;
                    candData = md_data;
                end
                if (pipe_we && md_valid && md_reg != ZERO_IDX) begin
                    if (pipe_reg == md_reg) begin
                        mdDropInt = 1'b1;
                    end else begin
                        bufLoad     = 1'b1;
                        nextState   = ST_HOLD;
                        nextHoldCnt = '0;
                    end
                end
            end
            ST_HOLD: begin
                candWe = 1'b1;
                if (!pipe_we) begin
                    candReg     = bufReg;
                    candData    = bufData;
                    bufClear    = 1'b1;
                    nextState   = ST_IDLE;
                    nextHoldCnt = '0;
                end else if (pipe_reg == bufReg) begin
                    candReg     = pipe_reg;
                    candData    = pipe_data;
                    bufClear    = 1'b1;
                    mdDropInt   = 1'b1;
                    nextState   = ST_IDLE;
                    nextHoldCnt = '0;
                end else begin
                    candReg     = pipe_reg;
                    candData    = pipe_data;
                    nextHoldCnt = holdCnt + 1'b1;
                    if (holdCnt == CNT_LAST) begin
                        nextState = ST_FORCE;
                        nextStall = 1'b1;
                    end
                end
            end
            ST_FORCE: begin
                candWe      = 1'b1;
                candReg     = bufReg;
                candData    = bufData;
                bufClear    = 1'b1;
                pipeErrInt  = pipe_we;
                nextState   = ST_IDLE;
                nextStall   = 1'b0;
                nextHoldCnt = '0;
            end
            default: begin
                nextState   = ST_IDLE;
                nextStall   = 1'b0;
                nextHoldCnt = '0;
            end
        endcase
    end

    assign rfWeInt    = ctrl_reset_n && candWe && (candReg != ZERO_IDX);
    assign rf_we      = rfWeInt;
    assign rf_reg     = rfWeInt ? candReg : '0;
    assign rf_data    = rfWeInt ? candData : '0;
    assign md_ready   = ctrl_reset_n && mdReadyInt;
    assign md_dropped = ctrl_reset_n && mdDropInt;
    assign pipe_err   = ctrl_reset_n && pipeErrInt;
    assign stall_pipe = stallReg;
    assign hold_valid = ctrl_reset_n && bufValid;
    assign hold_reg   = hold_valid ? bufReg : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, hand-written reset
// sequences, then randomized traffic against a queue-style reference model.
module tb_regfile_wb_arbiter;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int STARVE_LIMIT = 3;

    logic              clock;
    logic              ctrl_reset_n;
    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_reg;
    logic [DATA_W-1:0] pipe_data;
    logic              md_valid;
    logic [ADDR_W-1:0] md_reg;
    logic [DATA_W-1:0] md_data;
    logic              md_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_reg;
    logic [DATA_W-1:0] rf_data;
    logic              stall_pipe;
    logic              hold_valid;
    logic [ADDR_W-1:0] hold_reg;
    logic              md_dropped;
    logic              pipe_err;

    int passCount  = 0;
    int totalCount = 0;

    regfile_wb_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock       (clock),
        .ctrl_reset_n(ctrl_reset_n),
        .pipe_we     (pipe_we),
        .pipe_reg    (pipe_reg),
        .pipe_data   (pipe_data),
        .md_valid    (md_valid),
        .md_reg      (md_reg),
        .md_data     (md_data),
        .md_ready    (md_ready),
        .rf_we       (rf_we),
        .rf_reg      (rf_reg),
        .rf_data     (rf_data),
        .stall_pipe  (stall_pipe),
        .hold_valid  (hold_valid),
        .hold_reg    (hold_reg),
        .md_dropped  (md_dropped),
        .pipe_err    (pipe_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        pWe;
        logic [4:0]  pReg;
        logic [31:0] pData;
        logic        mValid;
        logic [4:0]  mReg;
        logic [31:0] mData;
        logic        eWe;
        logic [4:0]  eReg;
        logic [31:0] eData;
        logic        eRdy;
        logic        eStall;
        logic        eHv;
        logic [4:0]  eHr;
        logic        eDrop;
        logic        eErr;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the parked result, HOLD cycles lost so far, and a pending forced drain.
    bit          mHeld    = 0;
    logic [4:0]  mHReg    = '0;
    logic [31:0] mHData   = '0;
    int          mLost    = 0;
    bit          mForcing = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic rstN, input logic pWe, input logic [4:0] pReg,
                                 input logic [31:0] pData, input logic mValid,
                                 input logic [4:0] mReg, input logic [31:0] mData);
        @(negedge clock);
        ctrl_reset_n = rstN;
        pipe_we      = pWe;
        pipe_reg     = pReg;
        pipe_data    = pData;
        md_valid     = mValid;
        md_reg       = mReg;
        md_data      = mData;
        #1;
    endtask

    task automatic addVec(input logic pWe, input logic [4:0] pReg, input logic [31:0] pData,
                          input logic mValid, input logic [4:0] mReg, input logic [31:0] mData,
                          input logic eWe, input logic [4:0] eReg, input logic [31:0] eData,
                          input logic eRdy, input logic eStall, input logic eHv,
                          input logic [4:0] eHr, input logic eDrop, input logic eErr);
        vec_t v;
        v.pWe = pWe; v.pReg = pReg; v.pData = pData;
        v.mValid = mValid; v.mReg = mReg; v.mData = mData;
        v.eWe = eWe; v.eReg = eReg; v.eData = eData;
        v.eRdy = eRdy; v.eStall = eStall; v.eHv = eHv; v.eHr = eHr;
        v.eDrop = eDrop; v.eErr = eErr;
        vecs.push_back(v);
    endtask

    task automatic checkAll(input string tag, input logic eWe, input logic [4:0] eReg,
                            input logic [31:0] eData, input logic eRdy, input logic eStall,
                            input logic eHv, input logic [4:0] eHr, input logic eDrop, input logic eErr);
        checkOutput({tag, ".rf_we"}, 32'(rf_we), 32'(eWe));
        if (eWe) begin
            checkOutput({tag, ".rf_reg"}, 32'(rf_reg), 32'(eReg));
            checkOutput({tag, ".rf_data"}, rf_data, eData);
        end
        checkOutput({tag, ".md_ready"}, 32'(md_ready), 32'(eRdy));
        checkOutput({tag, ".stall_pipe"}, 32'(stall_pipe), 32'(eStall));
        checkOutput({tag, ".hold_valid"}, 32'(hold_valid), 32'(eHv));
        checkOutput({tag, ".hold_reg"}, 32'(hold_reg), 32'(eHr));
        checkOutput({tag, ".md_dropped"}, 32'(md_dropped), 32'(eDrop));
        checkOutput({tag, ".pipe_err"}, 32'(pipe_err), 32'(eErr));
    endtask

    // Produces this cycle's expected outputs from the model, then advances it past the edge.
    task automatic modelCycle(input logic rstN, input logic pWe, input logic [4:0] pReg,
                              input logic [31:0] pData, input logic mValid,
                              input logic [4:0] mReg, input logic [31:0] mData,
                              output logic eWe, output logic [4:0] eReg, output logic [31:0] eData,
                              output logic eRdy, output logic eStall, output logic eHv,
                              output logic [4:0] eHr, output logic eDrop, output logic eErr);
        bit          wr;
        logic [4:0]  wReg;
        logic [31:0] wData;
        wr = 0; wReg = '0; wData = '0;
        eRdy = 0; eDrop = 0; eErr = 0;
        eStall = mForcing;
        eHv = mHeld && rstN;
        eHr = eHv ? mHReg : 5'd0;
        if (!rstN) begin
            mHeld = 0; mLost = 0; mForcing = 0;
        end else if (mForcing) begin
            wr = 1; wReg = mHReg; wData = mHData;
            eErr = pWe;
            mHeld = 0; mLost = 0; mForcing = 0;
        end else if (mHeld) begin
            wr = 1;
            if (!pWe) begin
                wReg = mHReg; wData = mHData;
                mHeld = 0; mLost = 0;
            end else if (pReg == mHReg) begin
                wReg = pReg; wData = pData; eDrop = 1;
                mHeld = 0; mLost = 0;
            end else begin
                wReg = pReg; wData = pData;
                mLost++;
                if (mLost >= STARVE_LIMIT) mForcing = 1;
            end
        end else begin
            eRdy = 1;
            if (pWe) begin
                wr = 1; wReg = pReg; wData = pData;
            end else if (mValid) begin
                wr = 1; wReg = mReg; wData = mData;
            end
            if (pWe && mValid && mReg != 5'd0) begin
                if (pReg == mReg) eDrop = 1;
                else begin
                    mHeld = 1; mHReg = mReg; mHData = mData;
                end
            end
        end
        eWe = wr && (wReg != 5'd0);
        eReg = wReg;
        eData = wData;
    endtask

    initial begin
        logic        eWe, eRdy, eStall, eHv, eDrop, eErr;
        logic [4:0]  eReg, eHr;
        logic [31:0] eData;
        bit          mdPend;
        logic        rRst, rPWe;
        logic [4:0]  rPReg, rMReg;
        logic [31:0] rPData, rMData;

        ctrl_reset_n = 1'b0;
        pipe_we = 1'b0; pipe_reg = '0; pipe_data = '0;
        md_valid = 1'b0; md_reg = '0; md_data = '0;

        // Reset holds every strobe low even with both requesters active.
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
        checkAll("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkAll("reset2", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // pWe pReg pData mV mReg mData | eWe eReg eData eRdy eStall eHv eHr eDrop eErr
        addVec(0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 32'h0,    1, 0, 0, 0, 0, 0);
        addVec(1, 3, 32'hAAAA, 1, 7, 32'h1234,  1, 3, 32'hAAAA, 1, 0, 0, 0, 0, 0);
        addVec(0, 0, 32'h0,    0, 0, 32'h0,     1, 7, 32'h1234, 0, 0, 1, 7, 0, 0);
        addVec(0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 32'h0,    1, 0, 0, 0, 0, 0);
        addVec(1, 6, 32'h6666, 1, 7, 32'h77,    1, 6, 32'h6666, 1, 0, 0, 0, 0, 0);
        addVec(1, 1, 32'h11,   0, 0, 32'h0,     1, 1, 32'h11,   0, 0, 1, 7, 0, 0);
        addVec(1, 2, 32'h22,   0, 0, 32'h0,     1, 2, 32'h22,   0, 0, 1, 7, 0, 0);
        addVec(1, 4, 32'h44,   0, 0, 32'h0,     1, 4, 32'h44,   0, 0, 1, 7, 0, 0);
        addVec(0, 0, 32'h0,    0, 0, 32'h0,     1, 7, 32'h77,   0, 1, 1, 7, 0, 0);
        addVec(0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 32'h0,    1, 0, 0, 0, 0, 0);
        addVec(1, 2, 32'h20,   1, 9, 32'h99,    1, 2, 32'h20,   1, 0, 0, 0, 0, 0);
        addVec(1, 9, 32'h55,   0, 0, 32'h0,     1, 9, 32'h55,   0, 0, 1, 9, 1, 0);
        addVec(0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 32'h0,    1, 0, 0, 0, 0, 0);
        addVec(0, 0, 32'h0,    1, 0, 32'hFFFF,  0, 0, 32'h0,    1, 0, 0, 0, 0, 0);
        addVec(0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 32'h0,    1, 0, 0, 0, 0, 0);
        addVec(1, 1, 32'h1,    1, 8, 32'h88,    1, 1, 32'h1,    1, 0, 0, 0, 0, 0);
        addVec(1, 2, 32'h2,    0, 0, 32'h0,     1, 2, 32'h2,    0, 0, 1, 8, 0, 0);
        addVec(1, 3, 32'h3,    0, 0, 32'h0,     1, 3, 32'h3,    0, 0, 1, 8, 0, 0);
        addVec(1, 4, 32'h4,    0, 0, 32'h0,     1, 4, 32'h4,    0, 0, 1, 8, 0, 0);
        addVec(1, 5, 32'hDEAD, 0, 0, 32'h0,     1, 8, 32'h88,   0, 1, 1, 8, 0, 1);
        addVec(0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 32'h0,    1, 0, 0, 0, 0, 0);
        addVec(1, 6, 32'h66,   1, 6, 32'h67,    1, 6, 32'h66,   1, 0, 0, 0, 1, 0);
        addVec(0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 32'h0,    1, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(1'b1, vecs[i].pWe, vecs[i].pReg, vecs[i].pData,
                          vecs[i].mValid, vecs[i].mReg, vecs[i].mData);
            checkAll($sformatf("vec%0d", i), vecs[i].eWe, vecs[i].eReg, vecs[i].eData, vecs[i].eRdy,
                     vecs[i].eStall, vecs[i].eHv, vecs[i].eHr, vecs[i].eDrop, vecs[i].eErr);
        end

        // Reset while r5 is parked: the held result is lost and never reaches the regfile.
        applyStimulus(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd5, 32'h5555);
        checkAll("midHold.capture", 1, 1, 32'h1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkAll("midHold.reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkAll("midHold.after", 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // Reset during a forced drain clears the registered stall.
        applyStimulus(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd6, 32'h6);
        applyStimulus(1'b1, 1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b1, 1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkAll("forceReset.during", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkAll("forceReset.after", 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // Randomized traffic; the multdiv source holds its request until it transfers.
        mdPend = 0;
        rMReg = '0;
        rMData = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rRst = ($urandom_range(0, 59) != 0);
            rPWe = mForcing ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 9) < 6);
            rPReg = 5'($urandom_range(0, 7));
            rPData = $urandom;
            if (!mdPend && $urandom_range(0, 2) == 0) begin
                mdPend = 1;
                rMReg = 5'($urandom_range(0, 7));
                rMData = $urandom;
            end
            applyStimulus(rRst, rPWe, rPReg, rPData, mdPend, rMReg, rMData);
            modelCycle(rRst, rPWe, rPReg, rPData, mdPend, rMReg, rMData,
                       eWe, eReg, eData, eRdy, eStall, eHv, eHr, eDrop, eErr);
            checkAll($sformatf("rand%0d", cyc), eWe, eReg, eData, eRdy, eStall, eHv, eHr, eDrop, eErr);
            if (mdPend && eRdy) mdPend = 0;
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
